// File: rtl/rev_alu_pkg.sv
// Shared encodings for the reversible-gate scheduler: output selects, FSM
// states and the width of the completed-response counter.
package rev_alu_pkg;

  localparam logic [1:0] SEL_P   = 2'b00;
  localparam logic [1:0] SEL_Q   = 2'b01;
  localparam logic [1:0] SEL_R   = 2'b10;
  localparam logic [1:0] SEL_ILL = 2'b11;

  localparam int DONE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rev_gate_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found after last_grant, wrapping around.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IDW'((int'(last_grant) + off) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rev_gate_scheduler.sv
// Time-shares one external registered reversible gate among NREQ requesters:
// round-robin accept, wait out the gate latency, return one selected output.
module rev_gate_scheduler
  import rev_alu_pkg::*;
#(
  parameter  int W        = 32,
  parameter  int NREQ     = 2,
  parameter  int GATE_LAT = 1,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_sel,
  output logic [W-1:0]      gate_a,
  output logic [W-1:0]      gate_b,
  input  logic [W-1:0]      gate_p,
  input  logic [W-1:0]      gate_q,
  input  logic [W-1:0]      gate_r,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_err,
  output logic              busy,
  output logic [DONE_W-1:0] done_cnt
);

  // Counter wide enough for GATE_LAT, never zero bits wide (GATE_LAT may be 0).
  localparam int CW = $clog2(GATE_LAT + 2);

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] id_q;
  logic [1:0]     sel_q;
  logic [CW-1:0]  cnt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] gidx;

  function automatic logic [W-1:0] pick(input logic [1:0] sel,
                                        input logic [W-1:0] p,
                                        input logic [W-1:0] q,
                                        input logic [W-1:0] r);
    case (sel)
      SEL_P:   pick = p;
      SEL_Q:   pick = q;
      SEL_R:   pick = r;
      default: pick = '0;
    endcase
  endfunction

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = IDW'(i);
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      sel_q      <= '0;
      cnt        <= '0;
      gate_a     <= '0;
      gate_b     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            gate_a <= req_a[gidx*W +: W];
            gate_b <= req_b[gidx*W +: W];
            sel_q  <= req_sel[gidx*2 +: 2];
            id_q   <= gidx;
            cnt    <= CW'(GATE_LAT);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            resp_data  <= pick(sel_q, gate_p, gate_q, gate_r);
            resp_err   <= (sel_q == SEL_ILL);
            resp_id    <= id_q;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            last_grant <= id_q;
            done_cnt   <= done_cnt + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rev_gate_scheduler.sv
// Directed bench for rev_gate_scheduler with a one-cycle registered gate stub
// (P=A^B, Q=A&B, R=A|B).
module tb_rev_gate_scheduler;

  localparam int W    = 32;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*2-1:0] req_sel;
  logic [W-1:0]      gate_a, gate_b, gate_p, gate_q, gate_r;
  logic              resp_valid, resp_ready, resp_err, busy;
  logic [W-1:0]      resp_data;
  logic [0:0]        resp_id;
  logic [15:0]       done_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    gate_p <= gate_a ^ gate_b;
    gate_q <= gate_a & gate_b;
    gate_r <= gate_a | gate_b;
  end

  rev_gate_scheduler #(.W(W), .NREQ(NREQ), .GATE_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .gate_a     (gate_a),
    .gate_b     (gate_b),
    .gate_p     (gate_p),
    .gate_q     (gate_q),
    .gate_r     (gate_r),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gate_a"},     gate_a, 32'h0);
    chk({tag, "_gate_b"},     gate_b, 32'h0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    chk({tag, "_resp_data"},  resp_data, 32'h0);
    chk({tag, "_resp_id"},    32'(resp_id), 32'h0);
    chk({tag, "_resp_err"},   32'(resp_err), 32'h0);
    chk({tag, "_done_cnt"},   32'(done_cnt), 32'h0);
    chk({tag, "_busy"},       32'(busy), 32'h0);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sel);
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_sel[i*2 +: 2] = sel;
  endtask

  // Caller has raised req_valid; we are #1 after an edge.
  task automatic run_op(input string tag, input int g, input logic [31:0] a,
                        input logic [31:0] exp_data, input logic exp_err,
                        input logic drop);
    int lat;
    #1;
    for (int k = 0; k < 10 && req_ready == '0; k++) tick();
    chk({tag, "_grant"}, 32'(req_ready), 32'(1 << g));
    tick();
    if (drop) req_valid[g] = 1'b0;
    chk({tag, "_busy"},   32'(busy), 32'h1);
    chk({tag, "_gate_a"}, gate_a, a);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"},  32'(lat), 32'd2);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_id"},   32'(resp_id), 32'(g));
    chk({tag, "_err"},  32'(resp_err), 32'(exp_err));
    if (resp_ready) begin
      tick();
      chk({tag, "_vld_drop"}, 32'(resp_valid), 32'h0);
    end
  endtask

  initial begin
    logic [31:0] hold_data, hold_a, hold_b;
    logic [15:0] cnt0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sel    = '0;
    resp_ready = 1'b0;
    repeat (3) tick();
    chk_reset_state("rst0");
    chk("rst0_req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single op, P select
    resp_ready = 1'b1;
    set_req(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'b00);
    req_valid = 2'b01;
    run_op("single", 0, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, 1'b1);
    chk("single_done", 32'(done_cnt), 32'd1);
    chk("single_idle", 32'(busy), 32'h0);

    // Mid-cycle reset with non-zero state
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("rst1");
    chk("rst1_req_ready", 32'(req_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Contention: grants alternate 0,1,0,1
    set_req(0, 32'h12345678, 32'h87654321, 2'b10);
    set_req(1, 32'hFFFFFFFF, 32'h00000000, 2'b01);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) run_op("cont0", 0, 32'h12345678, 32'h97755779, 1'b0, 1'b0);
      else            run_op("cont1", 1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
    end
    chk("cont_done", 32'(done_cnt), 32'd4);
    req_valid = '0;
    tick();

    // Backpressure
    resp_ready = 1'b0;
    set_req(0, 32'hCAFEF00D, 32'h0000FFFF, 2'b00);
    req_valid = 2'b01;
    run_op("bp", 0, 32'hCAFEF00D, 32'hCAFE0FF2, 1'b0, 1'b1);
    hold_data = resp_data;
    hold_a    = gate_a;
    hold_b    = gate_b;
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(resp_valid), 32'h1);
      chk("bp_data",  resp_data, hold_data);
      chk("bp_id",    32'(resp_id), 32'h0);
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_gate",  gate_a ^ gate_b, hold_a ^ hold_b);
      chk("bp_gatea", gate_a, 32'hCAFEF00D);
    end
    chk("bp_done_hold", 32'(done_cnt), 32'd4);
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    chk("bp_release", 32'(resp_valid), 32'h0);
    chk("bp_done", 32'(done_cnt), 32'd5);

    // Illegal select
    cnt0 = done_cnt;
    set_req(0, 32'h0F0F0F0F, 32'hF0F0F0F0, 2'b11);
    req_valid = 2'b01;
    run_op("ill", 0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b1);
    chk("ill_done", 32'(done_cnt), 32'(cnt0 + 16'd1));

    // Reset while WAIT
    set_req(0, 32'h11111111, 32'h22222222, 2'b00);
    req_valid = 2'b10;
    set_req(1, 32'h33333333, 32'h44444444, 2'b00);
    #1;
    tick();
    chk("rw_busy", 32'(busy), 32'h1);
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("rw");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rw_noresp", 32'(resp_valid), 32'h0);
    end
    req_valid = 2'b11;
    #1;
    chk("rw_grant0", 32'(req_ready), 32'h1);
    run_op("rw_op", 0, 32'h11111111, 32'h33333333, 1'b0, 1'b1);
    req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
